// File: rtl/dpll_loop_ctrl.sv
// dpll_loop_ctrl: bang-bang DPLL loop controller.
// Turns phase-detector lead/lag pulses into DCO control-word corrections.
// Coarse steps are used while acquiring and fine steps once tracking.
// Lock is declared after a run of non-repeating evaluations.
// Lock is dropped after a run of same-direction corrections.
module dpll_loop_ctrl #(
  parameter logic [9:0]  CTRL_INIT = 10'd512,
  parameter logic [9:0]  STEP_C    = 10'd8,
  parameter logic [9:0]  STEP_F    = 10'd1,
  parameter int unsigned REV_N     = 4,
  parameter int unsigned LOCK_N    = 16,
  parameter int unsigned LOSS_N    = 4,
  parameter logic [9:0]  TMO       = 10'd1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lead,
  input  logic       lag,
  input  logic       ref_rise,
  input  logic [9:0] ref_period,
  output logic [9:0] dco_ctrl,
  output logic       ctrl_valid,
  output logic       locked,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // One shared run counter: only one state's count is live at a time, and
  // every state change clears it (reversals in ACQ, good evaluations in
  // TRACK, same-direction corrections in LOCKED).
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] REV_LIM  = CNT_W'(REV_N);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0] LOSS_LIM = CNT_W'(LOSS_N);

  state_t           state_q, state_d;
  dir_t             last_q, last_d;
  logic [9:0]       dco_q, dco_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       tmo_q, tmo_d;
  logic             ev_q, ev_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;

  logic             ev_up, ev_dn, ev_al, ev_corr;
  logic             is_first, is_repeat, is_reversal;
  logic [9:0]       step;
  logic [10:0]      up_sum;
  logic [9:0]       up_sat, dn_sat;
  logic [10:0]      tmo_inc;
  logic [CNT_W-1:0] cnt_inc;

  // Classify the evaluation and precompute saturated corrections.
  always_comb begin
    ev_up       = ev_q & lag & ~lead;
    ev_dn       = ev_q & lead & ~lag;
    ev_al       = ev_q & ~lead & ~lag;
    ev_corr     = ev_up | ev_dn;
    is_first    = ev_corr && (last_q == DIR_NONE);
    is_repeat   = (ev_up && (last_q == DIR_UP)) || (ev_dn && (last_q == DIR_DOWN));
    // ALIGNED always counts as a reversal; a correction only after a stored one.
    is_reversal = ev_al || (ev_corr && (last_q != DIR_NONE) && !is_repeat);
    step        = (state_q == S_ACQ) ? STEP_C : STEP_F;
    up_sum      = {1'b0, dco_q} + {1'b0, step};
    up_sat      = up_sum[10] ? 10'h3FF : up_sum[9:0];
    dn_sat      = (dco_q < step) ? 10'd0 : (dco_q - step);
    tmo_inc     = {1'b0, tmo_q} + 11'd1;
    cnt_inc     = cnt_q + CNT_W'(1);
  end

  // Next-state, correction and counter logic; the step was chosen from the
  // current state above, so a correction that also causes a transition
  // uses the step of the state being left.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dco_d   = dco_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    ev_d    = ref_rise;

    if (!en || (state_q == S_IDLE)) begin
      state_d = S_IDLE;
      dco_d   = CTRL_INIT;
      cnt_d   = '0;
      last_d  = DIR_NONE;
      tmo_d   = '0;
      if (en && ref_rise && (ref_period != 10'd0)) begin
        state_d = S_ACQ;
      end
    end else if (!ref_rise && (tmo_inc >= {1'b0, TMO})) begin
      // Reference lost: fall back to IDLE, dropping any pending evaluation.
      state_d = S_IDLE;
      dco_d   = CTRL_INIT;
      cnt_d   = '0;
      last_d  = DIR_NONE;
      tmo_d   = '0;
    end else begin
      tmo_d = ref_rise ? 10'd0 : tmo_inc[9:0];
      if (ev_up) dco_d = up_sat;
      if (ev_dn) dco_d = dn_sat;
      if (ev_corr) last_d = ev_up ? DIR_UP : DIR_DOWN;

      case (state_q)
        S_ACQ: begin
          if (is_reversal) begin
            if (cnt_inc >= REV_LIM) begin
              state_d = S_TRACK;
              cnt_d   = '0;
              last_d  = DIR_NONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_TRACK: begin
          // First correction after entry is not a repeat, so it counts good.
          if (is_reversal || is_first) begin
            if (cnt_inc >= LOCK_LIM) begin
              state_d = S_LOCKED;
              cnt_d   = '0;
              last_d  = DIR_NONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (is_repeat) begin
            cnt_d = '0;
          end
        end
        S_LOCKED: begin
          // First correction after entry starts the same-direction run.
          if (is_repeat || is_first) begin
            if (cnt_inc >= LOSS_LIM) begin
              state_d = S_ACQ;
              cnt_d   = '0;
              last_d  = DIR_NONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (is_reversal) begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    valid_d  = (dco_d != dco_q);
    locked_d = (state_d == S_LOCKED);
  end

  // Register all loop state and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= DIR_NONE;
      dco_q    <= CTRL_INIT;
      cnt_q    <= '0;
      tmo_q    <= '0;
      ev_q     <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      dco_q    <= dco_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      ev_q     <= ev_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign dco_ctrl   = dco_q;
  assign ctrl_valid = valid_q;
  assign locked     = locked_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// tb_dpll_loop_ctrl: table-driven directed scenario, hand-written corner
// sequences, then randomized stimulus checked against a behavioural model.
`timescale 1ns/1ps
module tb_dpll_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, lead, lag, ref_rise;
  logic [9:0] ref_period;
  logic [9:0] dco_ctrl;
  logic       ctrl_valid, locked;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  dpll_loop_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .lead(lead), .lag(lag),
    .ref_rise(ref_rise), .ref_period(ref_period),
    .dco_ctrl(dco_ctrl), .ctrl_valid(ctrl_valid), .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rr, ld, lg, en;
    int   st, dco;
    logic cv, lk;
  } vec_t;

  vec_t tbl[$];
  int   cur_st, cur_dco;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Table builders: expected values follow the loop rules by hand.
  task automatic add_ev(input logic ld, input logic lg, input int nst, input int ndco);
    vec_t v;
    v.rr = 1'b0; v.ld = ld; v.lg = lg; v.en = 1'b1;
    v.st = nst; v.dco = ndco; v.cv = (ndco != cur_dco); v.lk = (nst == 3);
    tbl.push_back(v);
    cur_st = nst; cur_dco = ndco;
  endtask

  task automatic add_pulse(input logic ld, input logic lg, input int nst, input int ndco);
    vec_t v;
    v.rr = 1'b1; v.ld = 1'b0; v.lg = 1'b0; v.en = 1'b1;
    v.st = cur_st; v.dco = cur_dco; v.cv = 1'b0; v.lk = (cur_st == 3);
    tbl.push_back(v);
    add_ev(ld, lg, nst, ndco);
  endtask

  // Hand-sequence helper: a ref_rise cycle, then the detector cycle.
  task automatic pulse(input logic ld, input logic lg);
    ref_rise = 1'b1; lead = 1'b0; lag = 1'b0;
    tick();
    ref_rise = 1'b0; lead = ld; lag = lg;
    tick();
    lead = 1'b0; lag = 1'b0;
  endtask

  task automatic enter_acq();
    en = 1'b1; ref_period = 10'd100; ref_rise = 1'b1;
    tick();
    ref_rise = 1'b0;
  endtask

  // Behavioural reference: loop state kept as plain integers.
  int m_st, m_dco, m_cnt, m_last, m_tmo;
  bit m_ev, m_cv;

  task automatic m_go_idle();
    m_st = 0; m_dco = 512; m_cnt = 0; m_last = 0; m_tmo = 0;
  endtask

  task automatic m_enter(input int s);
    m_st = s; m_cnt = 0; m_last = 0;
  endtask

  task automatic m_step(input bit r, input bit e, input bit rr, input bit ld,
                        input bit lg, input int per);
    int  prev, d, stp;
    bit  was_ev, rev, rep, first;
    prev   = m_dco;
    was_ev = m_ev;
    m_ev   = rr;
    if (r) begin
      m_go_idle(); m_ev = 0; m_cv = 0;
      return;
    end
    if (!e || m_st == 0) begin
      m_go_idle();
      if (e && rr && per != 0) m_st = 1;
    end else if (!rr && m_tmo + 1 >= 1023) begin
      m_go_idle();
    end else begin
      m_tmo = rr ? 0 : m_tmo + 1;
      if (was_ev && !(ld && lg)) begin
        d     = lg ? 1 : (ld ? -1 : 0);
        stp   = (m_st == 1) ? 8 : 1;
        m_dco = m_dco + d * stp;
        if (m_dco > 1023) m_dco = 1023;
        if (m_dco < 0) m_dco = 0;
        rev   = (d == 0) || (m_last != 0 && d != m_last);
        rep   = (d != 0) && (d == m_last);
        first = (d != 0) && (m_last == 0);
        if (d != 0) m_last = d;
        if (m_st == 1) begin
          if (rev) m_cnt++;
          if (m_cnt >= 4) m_enter(2);
        end else if (m_st == 2) begin
          if (rev || first) m_cnt++;
          else if (rep) m_cnt = 0;
          if (m_cnt >= 16) m_enter(3);
        end else begin
          if (rep || first) m_cnt++;
          else m_cnt = 0;
          if (m_cnt >= 4) m_enter(1);
        end
      end
    end
    m_cv = (m_dco != prev);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; lead = 1'b0; lag = 1'b0; ref_rise = 1'b0; ref_period = 10'd0;

    // Directed scenario table: acquire, track, lock, lose lock.
    cur_st = 1; cur_dco = 512;
    begin
      vec_t v0;
      v0.rr = 1'b1; v0.ld = 1'b0; v0.lg = 1'b0; v0.en = 1'b1;
      v0.st = 1; v0.dco = 512; v0.cv = 1'b0; v0.lk = 1'b0;
      tbl.push_back(v0);
    end
    add_ev(1'b0, 1'b1, 1, 520);
    add_pulse(1'b0, 1'b1, 1, 528);
    add_pulse(1'b0, 1'b1, 1, 536);
    add_pulse(1'b1, 1'b0, 1, 528);
    add_pulse(1'b0, 1'b1, 1, 536);
    add_pulse(1'b1, 1'b0, 1, 528);
    add_pulse(1'b0, 1'b1, 2, 536);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) add_pulse(1'b1, 1'b0, (i == 15) ? 3 : 2, 535);
      else            add_pulse(1'b0, 1'b1, (i == 15) ? 3 : 2, 536);
    end
    for (int i = 0; i < 4; i++) add_pulse(1'b1, 1'b0, (i == 3) ? 1 : 3, 535 - i);

    tick(); tick();
    chk("reset.state", state, 0);
    chk("reset.dco", dco_ctrl, 512);
    chk("reset.valid", ctrl_valid, 0);
    chk("reset.locked", locked, 0);
    rst = 1'b0; ref_period = 10'd100;

    for (int i = 0; i < tbl.size(); i++) begin
      ref_rise = tbl[i].rr; lead = tbl[i].ld; lag = tbl[i].lg; en = tbl[i].en;
      tick();
      chk($sformatf("vec%0d.state", i), state, tbl[i].st);
      chk($sformatf("vec%0d.dco", i), dco_ctrl, tbl[i].dco);
      chk($sformatf("vec%0d.valid", i), ctrl_valid, tbl[i].cv);
      chk($sformatf("vec%0d.locked", i), locked, tbl[i].lk);
      $display("vec %0d: rr=%b lead=%b lag=%b -> state=%0d dco=%0d valid=%b locked=%b",
               i, tbl[i].rr, tbl[i].ld, tbl[i].lg, state, dco_ctrl, ctrl_valid, locked);
    end
    ref_rise = 1'b0; lead = 1'b0; lag = 1'b0;

    // Upper saturation in ACQ: 532 + 61*8 = 1020, then clip at 1023.
    for (int i = 0; i < 61; i++) pulse(1'b0, 1'b1);
    chk("sat.pre", dco_ctrl, 1020);
    pulse(1'b0, 1'b1);
    chk("sat.clip", dco_ctrl, 1023);
    chk("sat.clip_valid", ctrl_valid, 1);
    pulse(1'b0, 1'b1);
    chk("sat.hold", dco_ctrl, 1023);
    chk("sat.hold_valid", ctrl_valid, 0);
    $display("sat: dco=%0d valid=%b", dco_ctrl, ctrl_valid);

    // Re-acquire and relock, then let the reference vanish.
    pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
    chk("relock.track", state, 2);
    chk("relock.dco", dco_ctrl, 1023);
    for (int i = 0; i < 16; i++) pulse(i % 2 == 0, i % 2 == 1);
    chk("relock.state", state, 3);
    chk("relock.locked", locked, 1);
    repeat (1021) tick();
    chk("tmo.before", state, 3);
    tick();
    chk("tmo.state", state, 0);
    chk("tmo.dco", dco_ctrl, 512);
    chk("tmo.locked", locked, 0);
    $display("timeout: state=%0d dco=%0d", state, dco_ctrl);

    // Invalid evaluation (both pulses) leaves the word untouched.
    enter_acq();
    chk("inv.enter", state, 1);
    pulse(1'b1, 1'b1);
    chk("inv.dco", dco_ctrl, 512);
    chk("inv.valid", ctrl_valid, 0);
    chk("inv.state", state, 1);

    // en=0 overrides a same-cycle correction.
    pulse(1'b0, 1'b1);
    chk("en0.pre", dco_ctrl, 520);
    ref_rise = 1'b1; tick(); ref_rise = 1'b0;
    en = 1'b0; lag = 1'b1; tick(); lag = 1'b0;
    chk("en0.state", state, 0);
    chk("en0.dco", dco_ctrl, 512);
    $display("en0: state=%0d dco=%0d", state, dco_ctrl);

    // Unmeasured reference period blocks acquisition.
    en = 1'b1; ref_period = 10'd0; ref_rise = 1'b1; tick(); ref_rise = 1'b0;
    chk("per0.state", state, 0);
    ref_period = 10'd100;

    // Reset mid-operation beats en and ref_rise.
    enter_acq();
    pulse(1'b0, 1'b1);
    chk("rstmid.pre", dco_ctrl, 520);
    rst = 1'b1; ref_rise = 1'b1; tick();
    rst = 1'b0; ref_rise = 1'b0;
    chk("rstmid.state", state, 0);
    chk("rstmid.dco", dco_ctrl, 512);
    chk("rstmid.valid", ctrl_valid, 0);
    $display("rstmid: state=%0d dco=%0d", state, dco_ctrl);

    // Randomized stimulus against the behavioural model.
    rst = 1'b1; tick(); rst = 1'b0;
    m_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 399) == 0);
      en         = ($urandom_range(0, 99) != 0);
      ref_rise   = ($urandom_range(0, 9) < 4);
      lead       = ($urandom_range(0, 2) == 0);
      lag        = ($urandom_range(0, 2) == 0);
      ref_period = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      m_step(rst, en, ref_rise, lead, lag, int'(ref_period));
      tick();
      chk($sformatf("rnd%0d.state", i), state, m_st);
      chk($sformatf("rnd%0d.dco", i), dco_ctrl, m_dco);
      chk($sformatf("rnd%0d.valid", i), ctrl_valid, m_cv);
      chk($sformatf("rnd%0d.locked", i), locked, m_st == 3);
    end
    $display("random: final state=%0d dco=%0d", state, dco_ctrl);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
